// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state encoding, port ids and counter widths shared by the memory arbiter.
package mem_arbiter_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY_0, ARB_BUSY_1} arb_state_t;
    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_DATA = 1'b1;
    localparam int STARVE_W = 4;
    localparam int TMO_W = 8;
    function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] c);
        return &c ? c : c + 1'b1;
    endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester enables, memory completion and arbiter status bundle.
interface mem_arbiter_if;
    logic req_0, req_1, valid, clear_err;
    logic select, enable_0_gated, enable_1_gated, busy, timeout_err;
    modport slave(
        input req_0, req_1, valid, clear_err,
        output select, enable_0_gated, enable_1_gated, busy, timeout_err
    );
    modport master(
        output req_0, req_1, valid, clear_err,
        input select, enable_0_gated, enable_1_gated, busy, timeout_err
    );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection among the eligible requesters.
module mem_arb_pick
    import mem_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                req_0,
    input  logic                req_1,
    input  logic                last_served,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic                any,
    output logic                winner
);
    logic contend_win;
    always_comb begin
        contend_win = FIXED_PRIO != 0
            ? (starve_cnt == STARVE_W'(STARVE_LIMIT) ? PORT_IFETCH : PORT_DATA)
            : ~last_served;
        any = req_0 | req_1;
        winner = (req_0 & req_1) ? contend_win : req_1;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the shared memory port to ifetch or load/store, holding the grant
// until valid, with zero-bubble handoff and a hung-memory timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic clk,
    input logic reset,
    mem_arbiter_if.slave bus
);
    arb_state_t state, state_nx;
    logic select_q, last_served, err_q;
    logic [STARVE_W-1:0] starve_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic idle, take, cand_0, cand_1, any, winner, req_cur, tmo_hit, err_set;

    // The completing port's req is still high in its valid cycle, so it is masked from arbitration.
    always_comb begin
        idle = state == ARB_IDLE;
        take = idle | bus.valid;
        cand_0 = bus.req_0 & take & (state != ARB_BUSY_0);
        cand_1 = bus.req_1 & take & (state != ARB_BUSY_1);
        req_cur = state == ARB_BUSY_1 ? bus.req_1 : bus.req_0;
        tmo_hit = TIMEOUT_CYCLES != 0 && !idle && !bus.valid && tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1);
        err_set = tmo_hit & req_cur;
    end

    mem_arb_pick #(
        .FIXED_PRIO(FIXED_PRIO),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .req_0(cand_0),
        .req_1(cand_1),
        .last_served(last_served),
        .starve_cnt(starve_cnt),
        .any(any),
        .winner(winner)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= ARB_IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = any ? (winner ? ARB_BUSY_1 : ARB_BUSY_0)
                 : (take | ~req_cur | tmo_hit) ? ARB_IDLE : state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            select_q <= PORT_IFETCH;
            last_served <= PORT_DATA;
            starve_cnt <= '0;
            tmo_cnt <= '0;
            err_q <= 1'b0;
        end else begin
            if (any) begin
                select_q <= winner;
                last_served <= winner;
                starve_cnt <= winner == PORT_IFETCH ? '0 : bus.req_0 ? starve_inc(starve_cnt) : starve_cnt;
            end
            tmo_cnt <= any ? '0 : (!idle && !(&tmo_cnt)) ? tmo_cnt + 1'b1 : tmo_cnt;
            err_q <= err_set | (err_q & ~bus.clear_err);
        end
    end

    always_comb begin
        bus.select = select_q;
        bus.enable_0_gated = bus.req_0 & (state == ARB_BUSY_0);
        bus.enable_1_gated = bus.req_1 & (state == ARB_BUSY_1);
        bus.busy = !idle;
        bus.timeout_err = err_q;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random stimulus on a round-robin and a fixed-priority arbiter,
// each compared every cycle against a transaction-level model.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    int vectors = 0;
    int miscompares = 0;
    string phase = "init";

    int fp[2] = '{0, 1};
    int lim[2] = '{4, 2};
    int tmo[2] = '{4, 0};
    int owner[2], last[2], starve[2], waited[2];
    bit err[2], sel[2];

    always #5 clk = ~clk;

    mem_arbiter_if bus_rr();
    mem_arbiter_if bus_fp();

    mem_arbiter #(.FIXED_PRIO(0), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(4)) dut_rr (
        .clk(clk), .reset(reset), .bus(bus_rr.slave)
    );
    mem_arbiter #(.FIXED_PRIO(1), .STARVE_LIMIT(2), .TIMEOUT_CYCLES(0)) dut_fp (
        .clk(clk), .reset(reset), .bus(bus_fp.slave)
    );

    task automatic check(string tag, logic [4:0] got, logic [4:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s/%s: got %b expected %b ({sel,en0,en1,busy,err})", phase, tag, got, exp);
        end
    endtask

    task automatic drive(bit r0, bit r1, bit v, bit clr);
        bus_rr.req_0 = r0; bus_rr.req_1 = r1; bus_rr.valid = v; bus_rr.clear_err = clr;
        bus_fp.req_0 = r0; bus_fp.req_1 = r1; bus_fp.valid = v; bus_fp.clear_err = clr;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1; last[k] = 1; starve[k] = 0; waited[k] = 0; err[k] = 0; sel[k] = 0;
        end
    endtask

    // owner: -1 when nobody holds the port, else the granted port number
    task automatic model_step(int k, bit r0, bit r1, bit v, bit clr);
        bit set = 0;
        int w = -1;
        if (owner[k] < 0 || v) begin
            bit c0 = r0 && owner[k] != 0;
            bit c1 = r1 && owner[k] != 1;
            if (c0 && c1) w = fp[k] != 0 ? (starve[k] == lim[k] ? 0 : 1) : 1 - last[k];
            else if (c0) w = 0;
            else if (c1) w = 1;
            if (w >= 0) begin
                if (w == 0) starve[k] = 0;
                else if (r0) starve[k] = starve[k] < 15 ? starve[k] + 1 : 15;
                last[k] = w; sel[k] = w[0]; waited[k] = 0;
            end
            owner[k] = w;
        end else if (!(owner[k] == 0 ? r0 : r1)) begin
            owner[k] = -1;
        end else begin
            waited[k]++;
            if (tmo[k] != 0 && waited[k] == tmo[k]) begin
                owner[k] = -1;
                set = 1;
            end
        end
        err[k] = set ? 1'b1 : clr ? 1'b0 : err[k];
    endtask

    function automatic logic [4:0] expect_vec(int k, bit r0, bit r1);
        return {sel[k], r0 && owner[k] == 0, r1 && owner[k] == 1, owner[k] >= 0, err[k]};
    endfunction

    task automatic cycle(bit r0, bit r1, bit v, bit clr);
        @(negedge clk);
        drive(r0, r1, v, clr);
        #1;
        check("rr", {bus_rr.select, bus_rr.enable_0_gated, bus_rr.enable_1_gated, bus_rr.busy, bus_rr.timeout_err},
              expect_vec(0, r0, r1));
        check("fp", {bus_fp.select, bus_fp.enable_0_gated, bus_fp.enable_1_gated, bus_fp.busy, bus_fp.timeout_err},
              expect_vec(1, r0, r1));
        @(posedge clk);
        model_step(0, r0, r1, v, clr);
        model_step(1, r0, r1, v, clr);
    endtask

    initial begin
        bit r0 = 0, r1 = 0;
        reset = 1'b1;
        drive(0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        phase = "reset";
        cycle(0, 0, 0, 0);
        phase = "single";
        repeat (3) cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 0);
        repeat (2) cycle(0, 0, 0, 0);
        phase = "contend";
        for (int i = 0; i < 12; i++) cycle(1, 1, i % 2 == 1, 0);
        repeat (2) cycle(0, 0, 0, 0);
        phase = "timeout";
        cycle(0, 1, 0, 0);
        repeat (5) cycle(1, 1, 0, 0);
        #1;
        check("rr_tmo_then_grant0", {2'b00, bus_rr.enable_0_gated, bus_rr.enable_1_gated, bus_rr.timeout_err},
              5'b00101);
        cycle(1, 1, 0, 1);
        repeat (2) cycle(0, 0, 0, 0);
        phase = "abort";
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        repeat (2) cycle(0, 0, 0, 0);
        phase = "async_rst";
        repeat (3) cycle(0, 1, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rr", {bus_rr.select, bus_rr.enable_0_gated, bus_rr.enable_1_gated, bus_rr.busy, bus_rr.timeout_err},
              5'b00000);
        check("fp", {bus_fp.select, bus_fp.enable_0_gated, bus_fp.enable_1_gated, bus_fp.busy, bus_fp.timeout_err},
              5'b00000);
        drive(0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) r0 = !r0;
            if ($urandom_range(0, 5) == 0) r1 = !r1;
            cycle(r0, r1, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
